// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller. Registered Moore FSM that sequences each
// instruction through fetch/decode/execute/memory/writeback, drives the
// datapath enables and mux selects, and hands ALUOp to the ALU decoder.
// Memory accesses stall on mem_ready; unsupported opcodes pulse illegal_op.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | read instruction at PC, PC+4; waits for mem_ready
// DECODE  | compute branch target (SignImm<<2), dispatch on opcode
// MEMADR  | compute load/store address A + SignImm
// MEMRD   | read data memory at ALUOut; waits for mem_ready
// MEMWB   | write loaded data to rt
// MEMWR   | write B to memory at ALUOut; waits for mem_ready
// EXEC    | R-type ALU operation A op B
// ALUWB   | write ALU result to rd
// BRANCH  | compare A - B, load PC with target if zero
// ADDIEX  | A + SignImm
// ADDIWB  | write ALU result to rt
// JUMP    | load PC with jump target
// 12..15  | unused, outputs idle, return to FETCH
module main_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    logic [3:0] state_q, state_d;

    // Ungated per-state outputs; reset gating is applied afterwards.
    logic       mem_write_s, ir_write_s, reg_write_s, pc_write_s, branch_s, illegal_s;
    logic       iord_s, memtoreg_s, regdst_s, alusrca_s;
    logic [1:0] alusrcb_s, pcsrc_s, aluop_s;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d     = S_FETCH;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        illegal_s   = 1'b0;
        iord_s      = 1'b0;
        memtoreg_s  = 1'b0;
        regdst_s    = 1'b0;
        alusrca_s   = 1'b0;
        alusrcb_s   = 2'b00;
        pcsrc_s     = 2'b00;
        aluop_s     = 2'b00;
        case (state_q)
            S_FETCH: begin
                alusrcb_s  = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (op == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else if (op == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d   = S_FETCH;
                    illegal_s = 1'b1;
                end
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord_s  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                memtoreg_s  = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                state_d     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                regdst_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b01;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_s    = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // While reset is held the state register may still show an in-flight
    // state, so enables are killed combinationally and selects park at
    // their FETCH values.
    assign MemWrite   = reset_n & mem_write_s;
    assign IRWrite    = reset_n & ir_write_s;
    assign RegWrite   = reset_n & reg_write_s;
    assign PCWrite    = reset_n & pc_write_s;
    assign Branch     = reset_n & branch_s;
    assign illegal_op = reset_n & illegal_s;
    assign IorD       = reset_n & iord_s;
    assign MemtoReg   = reset_n & memtoreg_s;
    assign RegDst     = reset_n & regdst_s;
    assign ALUSrcA    = reset_n & alusrca_s;
    assign ALUSrcB    = reset_n ? alusrcb_s : 2'b01;
    assign PCSrc      = reset_n ? pcsrc_s   : 2'b00;
    assign ALUOp      = reset_n ? aluop_s   : 2'b00;
    assign state      = state_q;

endmodule
